// File: rtl/gf2_mul_pkg.sv
// Shared types and width helpers for the GF(2)[x] split-multiplier datapath.
package gf2_mul_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic int calc_pw(input int cw);
    return 2 * cw - 1;
  endfunction

  function automatic int calc_rw(input int cw, input int nch);
    return 2 * cw * nch - 1;
  endfunction

  // Keeps the shift port at least one bit wide for the degenerate NCH=1 case.
  function automatic int calc_sw(input int nch);
    return (nch <= 1) ? 1 : $clog2(2 * nch - 1);
  endfunction

  function automatic int max_shift(input int nch);
    return 2 * nch - 2;
  endfunction

endpackage

// File: rtl/gf2_shift_place.sv
// Places a PW-bit chunk product at bit offset shift*CW inside an RW-bit word.
module gf2_shift_place
  import gf2_mul_pkg::*;
#(
  parameter int CW  = 3,
  parameter int NCH = 3,
  localparam int PW = calc_pw(CW),
  localparam int RW = calc_rw(CW, NCH),
  localparam int SW = calc_sw(NCH)
) (
  input  logic [PW-1:0] term,
  input  logic [SW-1:0] shift,
  output logic [RW-1:0] placed,
  output logic          legal
);

  localparam logic [SW-1:0] MAX_S = SW'(max_shift(NCH));

  int amt;

  assign legal = (shift <= MAX_S);

  // Illegal offsets contribute nothing, so the accumulator XOR is a no-op for them.
  always_comb begin
    amt    = CW * int'(shift);
    placed = '0;
    if (legal) begin
      placed = RW'(term) << amt;
    end
  end

endmodule

// File: rtl/gf2_overlap_accum.sv
// Overlap-add accumulator: XORs shifted chunk products into one unreduced
// carry-less product and hands it downstream over a valid/ready port.
module gf2_overlap_accum
  import gf2_mul_pkg::*;
#(
  parameter int CW   = 3,
  parameter int NCH  = 3,
  parameter int CNTW = 8,
  localparam int PW  = calc_pw(CW),
  localparam int RW  = calc_rw(CW, NCH),
  localparam int SW  = calc_sw(NCH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            pp_valid,
  output logic            pp_ready,
  input  logic [PW-1:0]   pp_data,
  input  logic [SW-1:0]   pp_shift,
  input  logic            pp_last,
  output logic            res_valid,
  input  logic            res_ready,
  output logic [RW-1:0]   res_data,
  output logic            res_err,
  output logic [CNTW-1:0] res_nterms
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; a source holds its payload stable until that edge, and ready
  // never depends combinationally on the opposite side's valid or ready.

  state_t          state;
  logic [RW-1:0]   acc;
  logic [CNTW-1:0] cnt;
  logic            err;

  logic [RW-1:0]   placed;
  logic            legal;
  logic            accept;
  logic [RW-1:0]   acc_next;
  logic [CNTW-1:0] cnt_next;
  logic            err_next;

  gf2_shift_place #(
    .CW  (CW),
    .NCH (NCH)
  ) u_place (
    .term   (pp_data),
    .shift  (pp_shift),
    .placed (placed),
    .legal  (legal)
  );

  assign accept = pp_valid & pp_ready;

  always_comb begin
    acc_next = acc ^ placed;
    err_next = err | ~legal;
    cnt_next = (cnt == {CNTW{1'b1}}) ? cnt : cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      err        <= 1'b0;
      pp_ready   <= 1'b1;
      res_valid  <= 1'b0;
      res_data   <= '0;
      res_err    <= 1'b0;
      res_nterms <= '0;
    end else begin
      case (state)
        IDLE, ACCUM: begin
          if (accept) begin
            acc <= acc_next;
            cnt <= cnt_next;
            err <= err_next;
            if (pp_last) begin
              // Result registers load the post-update values so the output
              // appears one edge after the last term.
              state      <= DONE;
              pp_ready   <= 1'b0;
              res_valid  <= 1'b1;
              res_data   <= acc_next;
              res_err    <= err_next;
              res_nterms <= cnt_next;
            end else begin
              state <= ACCUM;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            state      <= IDLE;
            acc        <= '0;
            cnt        <= '0;
            err        <= 1'b0;
            pp_ready   <= 1'b1;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_err    <= 1'b0;
            res_nterms <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          pp_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_overlap_accum.sv
// Self-checking bench for gf2_overlap_accum with CW=3, NCH=3 (PW=5, RW=17).
module tb_gf2_overlap_accum;

  localparam int CW   = 3;
  localparam int NCH  = 3;
  localparam int CNTW = 8;
  localparam int PW   = 5;
  localparam int RW   = 17;
  localparam int SW   = 3;
  localparam int W    = RW + 1 + CNTW;

  logic            clk;
  logic            rst_n;
  logic            pp_valid;
  logic            pp_ready;
  logic [PW-1:0]   pp_data;
  logic [SW-1:0]   pp_shift;
  logic            pp_last;
  logic            res_valid;
  logic            res_ready;
  logic [RW-1:0]   res_data;
  logic            res_err;
  logic [CNTW-1:0] res_nterms;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    int              n;
    logic [3:0][4:0] d;
    logic [3:0][2:0] s;
    logic [16:0]     data;
    logic            err;
    logic [7:0]      cnt;
  } vec_t;

  vec_t vecs[8];

  gf2_overlap_accum #(
    .CW   (CW),
    .NCH  (NCH),
    .CNTW (CNTW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pp_valid   (pp_valid),
    .pp_ready   (pp_ready),
    .pp_data    (pp_data),
    .pp_shift   (pp_shift),
    .pp_last    (pp_last),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_err    (res_err),
    .res_nterms (res_nterms)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic logic [4:0] clmul3(input logic [2:0] a, input logic [2:0] b);
    logic [4:0] r = '0;
    for (int i = 0; i < 3; i++) if (b[i]) r = r ^ (5'(a) << i);
    return r;
  endfunction

  function automatic logic [16:0] clmul9(input logic [8:0] a, input logic [8:0] b);
    logic [16:0] r = '0;
    for (int i = 0; i < 9; i++) if (b[i]) r = r ^ (17'(a) << i);
    return r;
  endfunction

  // scoreboard: compare every result transfer against the queue head
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %h, expected no result", {res_data, res_err, res_nterms});
      end else begin
        check("result", 64'({res_data, res_err, res_nterms}), 64'(exp_q.pop_front()));
      end
    end
  end

  // driver tasks; called in the phase just after a rising edge
  task automatic send_term(input logic [4:0] d, input logic [2:0] s, input logic last);
    int guard = 0;
    pp_valid = 1'b1;
    pp_data  = d;
    pp_shift = s;
    pp_last  = last;
    @(negedge clk);
    while (!pp_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!pp_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: pp_ready=%0b, required 1", pp_ready);
    end
    @(posedge clk);
    #1;
    pp_valid = 1'b0;
    pp_data  = $urandom_range(0, 31);
    pp_shift = $urandom_range(0, 7);
    pp_last  = $urandom_range(0, 1);
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: %0d results pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic set_vec(input int idx, input int n,
                         input logic [4:0] d0, input logic [2:0] s0,
                         input logic [4:0] d1, input logic [2:0] s1,
                         input logic [4:0] d2, input logic [2:0] s2,
                         input logic [4:0] d3, input logic [2:0] s3,
                         input logic [16:0] data, input logic err, input logic [7:0] cnt);
    vecs[idx].n    = n;
    vecs[idx].d    = {d3, d2, d1, d0};
    vecs[idx].s    = {s3, s2, s1, s0};
    vecs[idx].data = data;
    vecs[idx].err  = err;
    vecs[idx].cnt  = cnt;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_res_valid"},  64'(res_valid),  64'd0);
    check({tag, "_pp_ready"},   64'(pp_ready),   64'd1);
    check({tag, "_res_data"},   64'(res_data),   64'd0);
    check({tag, "_res_err"},    64'(res_err),    64'd0);
    check({tag, "_res_nterms"}, 64'(res_nterms), 64'd0);
  endtask

  initial begin
    logic [8:0]  a;
    logic [8:0]  b;
    logic [16:0] ref_p;

    rst_n     = 1'b0;
    pp_valid  = 1'b0;
    pp_data   = '0;
    pp_shift  = '0;
    pp_last   = 1'b0;
    res_ready = 1'b1;

    //      idx n  d0     s0    d1     s1    d2     s2    d3     s3    data       err   cnt
    set_vec(0, 1, 5'h1F, 3'd0, 5'h00, 3'd0, 5'h00, 3'd0, 5'h00, 3'd0, 17'h0001F, 1'b0, 8'd1);
    set_vec(1, 2, 5'h1F, 3'd0, 5'h1F, 3'd1, 5'h00, 3'd0, 5'h00, 3'd0, 17'h000E7, 1'b0, 8'd2);
    set_vec(2, 1, 5'h15, 3'd4, 5'h00, 3'd0, 5'h00, 3'd0, 5'h00, 3'd0, 17'h15000, 1'b0, 8'd1);
    set_vec(3, 2, 5'h1F, 3'd5, 5'h01, 3'd0, 5'h00, 3'd0, 5'h00, 3'd0, 17'h00001, 1'b1, 8'd2);
    set_vec(4, 1, 5'h1F, 3'd0, 5'h00, 3'd0, 5'h00, 3'd0, 5'h00, 3'd0, 17'h0001F, 1'b0, 8'd1);
    set_vec(5, 2, 5'h1F, 3'd7, 5'h1F, 3'd6, 5'h00, 3'd0, 5'h00, 3'd0, 17'h00000, 1'b1, 8'd2);
    set_vec(6, 3, 5'h0A, 3'd2, 5'h0A, 3'd2, 5'h11, 3'd3, 5'h00, 3'd0, 17'h02200, 1'b0, 8'd3);
    set_vec(7, 4, 5'h1F, 3'd0, 5'h1F, 3'd1, 5'h1F, 3'd2, 5'h1F, 3'd3, 17'h03927, 1'b0, 8'd4);

    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // table-driven products
    foreach (vecs[v]) begin
      exp_q.push_back({vecs[v].data, vecs[v].err, vecs[v].cnt});
      for (int k = 0; k < vecs[v].n; k++) begin
        send_term(vecs[v].d[k], vecs[v].s[k], (k == vecs[v].n - 1));
      end
    end
    drain();

    // full schoolbook chunk set against a whole-operand carry-less product
    for (int t = 0; t < 1000; t++) begin
      a     = 9'($urandom_range(0, 511));
      b     = 9'($urandom_range(0, 511));
      ref_p = clmul9(a, b);
      exp_q.push_back({ref_p, 1'b0, 8'd9});
      for (int i = 0; i < 3; i++) begin
        for (int j = 0; j < 3; j++) begin
          send_term(clmul3(a[3*i +: 3], b[3*j +: 3]), 3'(i + j), (i == 2 && j == 2));
        end
      end
    end
    drain();

    // term counter saturates; an even number of identical terms cancels
    exp_q.push_back({17'h00000, 1'b0, 8'hFF});
    for (int k = 0; k < 260; k++) send_term(5'h01, 3'd0, (k == 259));
    drain();

    // back-pressure: result held while a new term waits
    res_ready = 1'b0;
    exp_q.push_back({17'h0001F, 1'b0, 8'd1});
    send_term(5'h1F, 3'd0, 1'b1);
    exp_q.push_back({17'h00018, 1'b0, 8'd1});
    fork
      send_term(5'h03, 3'd1, 1'b1);
      begin
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          check("stall_pp_ready",  64'(pp_ready),  64'd0);
          check("stall_res_valid", 64'(res_valid), 64'd1);
          check("stall_res_data",  64'(res_data),  64'h1F);
        end
        @(posedge clk);
        #1;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_pp_ready",  64'(pp_ready),  64'd1);
        check("release_res_valid", 64'(res_valid), 64'd0);
      end
    join
    drain();

    // asynchronous reset in the middle of a product
    send_term(5'h1F, 3'd0, 1'b0);
    send_term(5'h1F, 3'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.push_back({17'h000C0, 1'b0, 8'd1});
    send_term(5'h03, 3'd2, 1'b1);
    drain();

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
